// File: rtl/matrix_alu.sv
// 4x4 matrix ALU: loads 16-bit-element matrices A and B, then computes ADD/SUB/SCALE/TRANS/MULTI.
// Optional macro ALU_REG_OUT_EN registers MemMatOut and FinishFlag (one cycle latency).
module matrix_alu (
  output logic         FinishFlag,
  output logic [255:0] MemMatOut,
  input  logic [255:0] MemMatIn,
  input  logic [2:0]   Op_Code,
  input  logic         Load_Matrix1,
  input  logic         Load_Matrix2,
  output logic         Load1,
  output logic         Load2,
  input  logic [7:0]   SOURCE2,
  input  logic         reset,
  input  logic         clk
);

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SCALE = 3'b011;
  localparam logic [2:0] OP_TRANS = 3'b100;
  localparam logic [2:0] OP_MULTI = 3'b101;

  logic [255:0] mat_a;
  logic [255:0] mat_b;
  logic [255:0] result;
  logic         result_ok;
  logic [15:0]  acc;
  logic [15:0]  scalar;

  // Row-major element access: element[r][c] lives at bits 16*(4r+c)+:16.
  function automatic logic [15:0] el(input logic [255:0] m, input int r, input int c);
    return m[16*(4*r+c) +: 16];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      mat_a <= '0;
      mat_b <= '0;
      Load1 <= 1'b0;
      Load2 <= 1'b0;
    end else begin
      if (Load_Matrix1) begin
        mat_a <= MemMatIn;
        Load1 <= 1'b1;
      end
      if (Load_Matrix2) begin
        mat_b <= MemMatIn;
        Load2 <= 1'b1;
      end
    end
  end

  assign scalar = {8'd0, SOURCE2};

  always_comb begin
    result    = '0;
    result_ok = 1'b0;
    acc       = '0;
    case (Op_Code)
      OP_ADD, OP_SUB, OP_MULTI: result_ok = Load1 && Load2;
      OP_SCALE, OP_TRANS:       result_ok = Load1;
      default:                  result_ok = 1'b0;
    endcase
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          acc = acc + el(mat_a, r, k) * el(mat_b, k, c);
        end
        case (Op_Code)
          OP_ADD:   result[16*(4*r+c) +: 16] = el(mat_a, r, c) + el(mat_b, r, c);
          OP_SUB:   result[16*(4*r+c) +: 16] = el(mat_a, r, c) - el(mat_b, r, c);
          OP_SCALE: result[16*(4*r+c) +: 16] = el(mat_a, r, c) * scalar;
          OP_TRANS: result[16*(4*r+c) +: 16] = el(mat_a, c, r);
          OP_MULTI: result[16*(4*r+c) +: 16] = acc;
          default:  result[16*(4*r+c) +: 16] = 16'd0;
        endcase
      end
    end
    // Missing operands or a no-op code force an all-zero result.
    if (!result_ok) result = '0;
  end

`ifdef ALU_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      FinishFlag <= 1'b0;
      MemMatOut  <= '0;
    end else begin
      FinishFlag <= result_ok;
      MemMatOut  <= result;
    end
  end
`else
  assign FinishFlag = result_ok;
  assign MemMatOut  = result;
`endif

endmodule

// File: tb/tb_matrix_alu.sv
// Directed bench for matrix_alu (default combinational-output build).
// Expected values are hand-computed from the A/B reference matrices.
module tb_matrix_alu;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] MemMatIn;
  logic [2:0]   Op_Code;
  logic         Load_Matrix1;
  logic         Load_Matrix2;
  logic [7:0]   SOURCE2;
  logic         FinishFlag;
  logic [255:0] MemMatOut;
  logic         Load1;
  logic         Load2;

  int n_checks = 0;
  int n_pass   = 0;

  matrix_alu dut (
    .FinishFlag   (FinishFlag),
    .MemMatOut    (MemMatOut),
    .MemMatIn     (MemMatIn),
    .Op_Code      (Op_Code),
    .Load_Matrix1 (Load_Matrix1),
    .Load_Matrix2 (Load_Matrix2),
    .Load1        (Load1),
    .Load2        (Load2),
    .SOURCE2      (SOURCE2),
    .reset        (reset),
    .clk          (clk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] row(input int e0, input int e1, input int e2, input int e3);
    return {e3[15:0], e2[15:0], e1[15:0], e0[15:0]};
  endfunction

  task automatic check_row(input string tag, input int r, input logic [63:0] exp);
    check(tag, {192'd0, MemMatOut[64*r +: 64]}, {192'd0, exp});
  endtask

  function automatic logic [255:0] pk(input int e [16]);
    logic [255:0] m = '0;
    for (int i = 0; i < 16; i++) m[16*i +: 16] = e[i][15:0];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op);
    Op_Code = op;
    #1;
  endtask

  int a_el [16] = '{5,8,9,2, 7,3,8,4, 6,5,4,3, 8,5,7,6};
  int b_el [16] = '{11,14,19,18, 6,9,3,5, 12,10,15,14, 1,3,5,7};
  int a2_el[16] = '{10,16,18,4, 14,6,16,8, 12,10,8,6, 16,10,14,12};
  logic [255:0] mat_a, mat_b, mat_2a;

  initial begin
    mat_a  = pk(a_el);
    mat_b  = pk(b_el);
    mat_2a = pk(a2_el);
    reset = 1'b0; MemMatIn = '0; Op_Code = 3'b001;
    Load_Matrix1 = 1'b0; Load_Matrix2 = 1'b0; SOURCE2 = 8'd5;

    tick();
    reset = 1'b1;
    tick();
    check("rst_load1", {255'd0, Load1}, 256'd0);
    check("rst_load2", {255'd0, Load2}, 256'd0);
    check("rst_flag", {255'd0, FinishFlag}, 256'd0);
    check("rst_out", MemMatOut, 256'd0);

    // A only
    MemMatIn = mat_a; Load_Matrix1 = 1'b1;
    tick();
    Load_Matrix1 = 1'b0; MemMatIn = '0;
    check("load1_set", {255'd0, Load1}, 256'd1);
    check("load2_clear", {255'd0, Load2}, 256'd0);
    set_op(3'b001);
    check("add_noB_flag", {255'd0, FinishFlag}, 256'd0);
    check("add_noB_out", MemMatOut, 256'd0);
    set_op(3'b100);
    check("trans_onlyA_flag", {255'd0, FinishFlag}, 256'd1);
    check_row("trans_onlyA_r0", 0, row(5,7,6,8));
    set_op(3'b011);
    check("scale_onlyA_flag", {255'd0, FinishFlag}, 256'd1);

    // B too
    MemMatIn = mat_b; Load_Matrix2 = 1'b1;
    tick();
    Load_Matrix2 = 1'b0; MemMatIn = '0;
    check("load2_set", {255'd0, Load2}, 256'd1);
    set_op(3'b001);
    check("add_flag", {255'd0, FinishFlag}, 256'd1);
    check_row("add_r0", 0, row(16,22,28,20));
    set_op(3'b010);
    check_row("sub_r0", 0, row(65530,65530,65526,65520));
    set_op(3'b011);
    check_row("scale_r0", 0, row(25,40,45,10));
    check_row("scale_r3", 3, row(40,25,35,30));
    set_op(3'b100);
    check_row("trans_r0", 0, row(5,7,6,8));
    check_row("trans_r1", 1, row(8,3,5,5));
    set_op(3'b101);
    check("multi_flag", {255'd0, FinishFlag}, 256'd1);
    check_row("multi_r0", 0, row(213,238,264,270));
    check("multi_r1c0", {240'd0, MemMatOut[16*4 +: 16]}, 256'd195);
    set_op(3'b000);
    check("op000_flag", {255'd0, FinishFlag}, 256'd0);
    check("op000_out", MemMatOut, 256'd0);
    set_op(3'b111);
    check("op111_flag", {255'd0, FinishFlag}, 256'd0);
    check("op111_out", MemMatOut, 256'd0);

    // Both strobes together: A and B both become A
    MemMatIn = mat_a; Load_Matrix1 = 1'b1; Load_Matrix2 = 1'b1;
    tick();
    Load_Matrix1 = 1'b0; Load_Matrix2 = 1'b0; MemMatIn = '0;
    set_op(3'b001);
    check_row("dual_add_r0", 0, row(10,16,18,4));
    check("dual_add_full", MemMatOut, mat_2a);
    check("dual_flags", {254'd0, Load1, Load2}, 256'd3);

    // Reset mid-use, with a load strobe in the same edge
    reset = 1'b0; MemMatIn = mat_a; Load_Matrix1 = 1'b1;
    tick();
    reset = 1'b1; Load_Matrix1 = 1'b0; MemMatIn = '0;
    #1;
    check("midrst_flags", {254'd0, Load1, Load2}, 256'd0);
    check("midrst_flag", {255'd0, FinishFlag}, 256'd0);
    check("midrst_out", MemMatOut, 256'd0);

    // Modulo-2^16 wrap
    MemMatIn = {16{16'hFFFF}}; Load_Matrix1 = 1'b1;
    tick();
    MemMatIn = {16{16'h0002}}; Load_Matrix1 = 1'b0; Load_Matrix2 = 1'b1;
    tick();
    Load_Matrix2 = 1'b0; MemMatIn = '0;
    set_op(3'b001);
    check("wrap_add", MemMatOut, {16{16'h0001}});
    SOURCE2 = 8'd255;
    set_op(3'b011);
    check("wrap_scale", MemMatOut, {16{16'hFF01}});
    set_op(3'b101);
    check("wrap_multi", MemMatOut, {16{16'hFFF8}});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
